// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised byte-addressable data memory behind a load/store request port
//
// Purpose: accepts one load/store request through a valid/ready handshake. It waits
// WAIT_STATES cycles and then returns a one-cycle response pulse. The response
// carries the load data and an error flag.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_valid       request present (held by the requester until accepted)
//   req_ready       IDLE and not in reset
//   mem_rw          1 = store, 0 = load
//   write_strobe    store size: 00 byte, 01 half, 10 word, 11 reserved
//   func3           load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   addr, wdata     byte address, right-aligned store data
//   rsp_valid       one-cycle response pulse
//   rdata, err      load result and error flag, valid with rsp_valid, held otherwise
//   busy            high in WAIT and RESP
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_rw,
    input  logic [1:0]  write_strobe,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit HAS_WAIT = (WAIT_STATES > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        accept;
    logic        commit;
    logic        commit_en;

    logic        rw_q;
    logic [1:0]  ws_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        op_rw;
    logic [1:0]  op_ws;
    logic [2:0]  op_f3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;

    logic [IDX_W-1:0] idx;
    logic [1:0]  off;
    logic        op_err;
    logic [3:0]  lane_en;
    logic [31:0] store_data;
    logic [31:0] word_rd;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    logic [31:0] mem [DEPTH_WORDS];

    logic        unused_addr_hi;
    assign unused_addr_hi = ^addr_q[31:IDX_W+2] ^ ^addr[31:IDX_W+2];

    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign commit_en = commit && !rst;

    // With no wait states the commit edge is the accept edge, so the operation
    // has to be decoded straight from the request inputs rather than the holding registers.
    always_comb begin
        if (state == S_IDLE) begin
            op_rw    = mem_rw;
            op_ws    = write_strobe;
            op_f3    = func3;
            op_addr  = addr;
            op_wdata = wdata;
        end else begin
            op_rw    = rw_q;
            op_ws    = ws_q;
            op_f3    = f3_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
    end

    assign idx = op_addr[IDX_W+1:2];
    assign off = op_addr[1:0];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_next = CNT_INIT;
                    if (HAS_WAIT) begin
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_RESP;
                        commit     = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = S_RESP;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        op_err = 1'b0;
        if (op_rw) begin
            case (op_ws)
                2'b00:   op_err = 1'b0;
                2'b01:   op_err = off[0];
                2'b10:   op_err = (off != 2'd0);
                default: op_err = 1'b1;
            endcase
        end else begin
            case (op_f3)
                3'b000, 3'b100: op_err = 1'b0;
                3'b001, 3'b101: op_err = off[0];
                3'b010:         op_err = (off != 2'd0);
                default:        op_err = 1'b1;
            endcase
        end
    end

    // Store data is replicated across lanes so the lane enable alone selects the target bytes.
    always_comb begin
        lane_en    = 4'b0000;
        store_data = op_wdata;
        case (op_ws)
            2'b00: begin
                lane_en    = 4'b0001 << off;
                store_data = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                lane_en    = off[1] ? 4'b1100 : 4'b0011;
                store_data = {2{op_wdata[15:0]}};
            end
            2'b10: begin
                lane_en    = 4'b1111;
                store_data = op_wdata;
            end
            default: begin
                lane_en    = 4'b0000;
                store_data = op_wdata;
            end
        endcase
    end

    assign word_rd = mem[idx];

    always_comb begin
        byte_sel = word_rd[7:0];
        case (off)
            2'd0: byte_sel = word_rd[7:0];
            2'd1: byte_sel = word_rd[15:8];
            2'd2: byte_sel = word_rd[23:16];
            2'd3: byte_sel = word_rd[31:24];
            default: byte_sel = word_rd[7:0];
        endcase
        half_sel = off[1] ? word_rd[31:16] : word_rd[15:0];
        case (op_f3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = word_rd;
            3'b100:  load_val = {24'd0, byte_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = 32'd0;
        endcase
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit_en && op_rw && !op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rdata   <= 32'd0;
            err     <= 1'b0;
            rw_q    <= 1'b0;
            ws_q    <= 2'd0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                rw_q    <= mem_rw;
                ws_q    <= write_strobe;
                f3_q    <= func3;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (commit) begin
                err   <= op_err;
                rdata <= (op_rw || op_err) ? 32'd0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
//
// Purpose: drives two instances, one with WAIT_STATES=1 (index 0) and one with
// WAIT_STATES=0 (index 1), and compares every response against a word-array model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int WS_A  = 1;
    localparam int WS_B  = 0;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        mem_rw       [2];
    logic [1:0]  write_strobe [2];
    logic [2:0]  func3        [2];
    logic [31:0] addr         [2];
    logic [31:0] wdata        [2];
    logic        rsp_valid    [2];
    logic [31:0] rdata        [2];
    logic        err          [2];
    logic        busy         [2];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) u_dut_ws1 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .mem_rw(mem_rw[0]), .write_strobe(write_strobe[0]), .func3(func3[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rsp_valid(rsp_valid[0]), .rdata(rdata[0]),
        .err(err[0]), .busy(busy[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B)) u_dut_ws0 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .mem_rw(mem_rw[1]), .write_strobe(write_strobe[1]), .func3(func3[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rsp_valid(rsp_valid[1]), .rdata(rdata[1]),
        .err(err[1]), .busy(busy[1])
    );

    logic [31:0] mdl [2][DEPTH];
    int checks = 0;
    int errors = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? WS_A : WS_B;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: an access of 'size' bytes must start at a multiple of 'size';
    // a store writes those bytes, a load shifts the word down and extends.
    task automatic model_op(input int d, input logic rw, input logic [1:0] ws, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] er, output logic ee);
        int w;
        int o;
        int size;
        logic [31:0] word;
        w    = int'((a >> 2) % DEPTH);
        o    = int'(a % 4);
        size = 0;
        er   = 32'd0;
        ee   = 1'b0;
        if (rw) begin
            case (ws)
                2'd0: size = 1;
                2'd1: size = 2;
                2'd2: size = 4;
                default: size = 0;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: size = 1;
                3'd1, 3'd5: size = 2;
                3'd2:       size = 4;
                default:    size = 0;
            endcase
        end
        if (size == 0 || (o % size) != 0) begin
            ee = 1'b1;
            return;
        end
        if (rw) begin
            for (int k = 0; k < size; k++) mdl[d][w][8*(o+k) +: 8] = wd[8*k +: 8];
        end else begin
            word = mdl[d][w] >> (8 * o);
            case (f3)
                3'd0: er = 32'($signed(word[7:0]));
                3'd1: er = 32'($signed(word[15:0]));
                3'd4: er = {24'd0, word[7:0]};
                3'd5: er = {16'd0, word[15:0]};
                default: er = word;
            endcase
        end
    endtask

    task automatic txn(input int d, input logic rw, input logic [1:0] ws, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input string tag,
                       output logic [31:0] rd, output logic e);
        logic [31:0] er;
        logic        ee;
        int n;
        int k;
        @(negedge clk);
        mem_rw[d] = rw; write_strobe[d] = ws; func3[d] = f3; addr[d] = a; wdata[d] = wd;
        req_valid[d] = 1'b1;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid[d] = 1'b0;
            rd = 32'd0;
            e = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        addr[d] = $urandom();
        wdata[d] = $urandom();
        mem_rw[d] = ~rw;
        model_op(d, rw, ws, f3, a, wd, er, ee);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (rsp_valid[d] !== 1'b1 && k < 20);
        check({tag, "_latency"}, 32'(k), 32'(ws_of(d) + 1));
        rd = rdata[d];
        e  = err[d];
        check({tag, "_rdata"}, rd, er);
        check({tag, "_err"}, {31'd0, e}, {31'd0, ee});
        @(negedge clk);
        check({tag, "_pulse_end"}, {31'd0, rsp_valid[d]}, 32'd0);
        check({tag, "_rdata_hold"}, rdata[d], er);
    endtask

    task automatic handshake(input int d, input int gap);
        int acc[$];
        @(negedge clk);
        mem_rw[d] = 1'b0; func3[d] = 3'b010; write_strobe[d] = 2'b00; addr[d] = 32'h10;
        req_valid[d] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check("hs_ready_vs_busy", {31'd0, req_ready[d]}, {31'd0, ~busy[d]});
            if (req_ready[d] === 1'b1) acc.push_back(c);
            @(negedge clk);
        end
        req_valid[d] = 1'b0;
        check("hs_accept_count", 32'(acc.size()), 32'((12 + gap - 1) / gap));
        for (int i = 1; i < acc.size(); i++) begin
            check("hs_accept_gap", 32'(acc[i] - acc[i-1]), 32'(gap));
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        logic [31:0] pre;
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; mem_rw[d] = 1'b0; write_strobe[d] = 2'b00;
            func3[d] = 3'b000; addr[d] = 32'd0; wdata[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ready_low", {31'd0, req_ready[d]}, 32'd0);
            check("reset_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
            check("reset_rdata", rdata[d], 32'd0);
            check("reset_err", {31'd0, err[d]}, 32'd0);
            check("reset_busy", {31'd0, busy[d]}, 32'd0);
            rst[d] = 1'b0;
        end
        @(negedge clk);
        check("ready_after_reset", {31'd0, req_ready[0]}, 32'd1);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                txn(d, 1'b1, 2'b10, 3'b000, 32'(i * 4), $urandom(), "init_sw", rd, e);
            end
        end

        txn(0, 1'b1, 2'b10, 3'b000, 32'h10, 32'hDEADBEEF, "t1_sw", rd, e);
        check("t1_sw_err", {31'd0, e}, 32'd0);
        txn(0, 1'b0, 2'b00, 3'b010, 32'h10, 32'h0, "t1_lw", rd, e);
        check("t1_lw_value", rd, 32'hDEADBEEF);

        txn(0, 1'b1, 2'b00, 3'b000, 32'h11, 32'h000000AA, "t2_sb", rd, e);
        txn(0, 1'b0, 2'b00, 3'b010, 32'h10, 32'h0, "t2_lw", rd, e);
        check("t2_lw_value", rd, 32'hDEADAAEF);
        txn(0, 1'b0, 2'b00, 3'b000, 32'h11, 32'h0, "t2_lb", rd, e);
        check("t2_lb_value", rd, 32'hFFFFFFAA);
        txn(0, 1'b0, 2'b00, 3'b100, 32'h11, 32'h0, "t2_lbu", rd, e);
        check("t2_lbu_value", rd, 32'h000000AA);

        txn(0, 1'b1, 2'b01, 3'b000, 32'h12, 32'h00001234, "t3_sh", rd, e);
        txn(0, 1'b0, 2'b00, 3'b010, 32'h10, 32'h0, "t3_lw", rd, e);
        check("t3_lw_value", rd, 32'h1234AAEF);
        txn(0, 1'b0, 2'b00, 3'b001, 32'h12, 32'h0, "t3_lh", rd, e);
        check("t3_lh_value", rd, 32'h00001234);
        txn(0, 1'b1, 2'b01, 3'b000, 32'h12, 32'h00008001, "t3_sh2", rd, e);
        txn(0, 1'b0, 2'b00, 3'b001, 32'h12, 32'h0, "t3_lh2", rd, e);
        check("t3_lh2_value", rd, 32'hFFFF8001);
        txn(0, 1'b0, 2'b00, 3'b101, 32'h12, 32'h0, "t3_lhu", rd, e);
        check("t3_lhu_value", rd, 32'h00008001);

        txn(0, 1'b1, 2'b10, 3'b000, 32'h13, 32'h55555555, "t4_sw_mis", rd, e);
        check("t4_sw_mis_err", {31'd0, e}, 32'd1);
        txn(0, 1'b0, 2'b00, 3'b010, 32'h10, 32'h0, "t4_lw", rd, e);
        check("t4_lw_value", rd, 32'h8001AAEF);
        txn(0, 1'b0, 2'b00, 3'b001, 32'h11, 32'h0, "t4_lh_mis", rd, e);
        check("t4_lh_mis_err", {31'd0, e}, 32'd1);
        check("t4_lh_mis_rdata", rd, 32'd0);
        txn(0, 1'b0, 2'b00, 3'b011, 32'h10, 32'h0, "t4_f3_bad", rd, e);
        check("t4_f3_bad_err", {31'd0, e}, 32'd1);
        txn(0, 1'b1, 2'b11, 3'b000, 32'h10, 32'h12345678, "t4_ws_bad", rd, e);
        check("t4_ws_bad_err", {31'd0, e}, 32'd1);

        handshake(0, 3);
        handshake(1, 2);

        // Reset while the store waits: the write must never land.
        pre = mdl[0][8];
        @(negedge clk);
        mem_rw[0] = 1'b1; write_strobe[0] = 2'b10; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t6_busy_in_wait", {31'd0, busy[0]}, 32'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        check("t6_ready_in_rst", {31'd0, req_ready[0]}, 32'd0);
        check("t6_no_rsp", {31'd0, rsp_valid[0]}, 32'd0);
        check("t6_busy_cleared", {31'd0, busy[0]}, 32'd0);
        rst[0] = 1'b0;
        @(negedge clk);
        check("t6_no_rsp_after", {31'd0, rsp_valid[0]}, 32'd0);
        check("t6_ready_after", {31'd0, req_ready[0]}, 32'd1);
        txn(0, 1'b0, 2'b00, 3'b010, 32'h20, 32'h0, "t6_lw", rd, e);
        check("t6_lw_pretest", rd, pre);

        txn(0, 1'b1, 2'b10, 3'b000, 32'h1000, 32'h0BADF00D, "t6_alias_sw", rd, e);
        txn(0, 1'b0, 2'b00, 3'b010, 32'h0, 32'h0, "t6_alias_lw", rd, e);
        check("t6_alias_value", rd, 32'h0BADF00D);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 80; i++) begin
                a = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
                txn(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    a, $urandom(), "rand", rd, e);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
